// File: rtl/fdtd_pkg.sv
// fdtd_pkg: shared FDTD datapath types and constants.
//   FDTD_DATA_WIDTH : default data word width
//   fdtd_word_t     : one datapath word at the default width
//   ptr_width()     : width of a FIFO pointer (index plus one wrap bit)
package fdtd_pkg;

    localparam int unsigned FDTD_DATA_WIDTH = 32;

    typedef logic [FDTD_DATA_WIDTH-1:0] fdtd_word_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fdtd_pipe_drain_buffer_if.sv
// fdtd_pipe_drain_buffer_if: handshake bundle of the pipeline drain buffer.
//   issue_i/credit_o   upstream issue and credit
//   valid_i/data_i     pipeline tail word
//   valid_o/data_o     buffer head (first-word fall-through), ready_i accepts it
//   count_o            stored entries
//   err_o              sticky protocol error
// Modports: slave = the buffer, master = the surrounding pipeline/consumer.
interface fdtd_pipe_drain_buffer_if #(
    parameter int unsigned FDTD_DATA_WIDTH = fdtd_pkg::FDTD_DATA_WIDTH,
    parameter int unsigned DEPTH           = 8
);
    logic                         issue_i;
    logic                         credit_o;
    logic                         valid_i;
    logic [FDTD_DATA_WIDTH-1:0]   data_i;
    logic                         valid_o;
    logic [FDTD_DATA_WIDTH-1:0]   data_o;
    logic                         ready_i;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    logic                         err_o;

    modport slave (
        input  issue_i, valid_i, data_i, ready_i,
        output credit_o, valid_o, data_o, count_o, err_o
    );

    modport master (
        output issue_i, valid_i, data_i, ready_i,
        input  credit_o, valid_o, data_o, count_o, err_o
    );
endinterface

// File: rtl/fdtd_drain_mem.sv
// fdtd_drain_mem: DEPTH x WIDTH register array for the drain buffer.
//   CLK         clock
//   we/waddr/wdata  single synchronous write port
//   raddr/rdata     asynchronous read port
// Contents are not reset; the owning FIFO tracks validity with its pointers.
module fdtd_drain_mem #(
    parameter int unsigned WIDTH = fdtd_pkg::FDTD_DATA_WIDTH,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fdtd_pipe_drain_buffer.sv
// fdtd_pipe_drain_buffer: receive end of the FDTD fixed-latency datapath.
// Buffers the pipeline tail so that a stalled downstream never loses words,
// and grants upstream issue credit covering stored plus in-flight words.
//   CLK, RST_N  clock, asynchronous active-low reset
//   bus         fdtd_pipe_drain_buffer_if.slave (issue/credit, tail in, head out,
//               count, sticky error)
// Optional: define FDTD_DRAIN_CHECK_EN to build the sticky protocol checker on
// err_o; otherwise err_o is tied low and the datapath is unchanged.
module fdtd_pipe_drain_buffer #(
    parameter int unsigned FDTD_DATA_WIDTH = fdtd_pkg::FDTD_DATA_WIDTH,
    parameter int unsigned PIPE_LATENCY    = 2,
    parameter int unsigned DEPTH           = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    fdtd_pipe_drain_buffer_if.slave   bus
);
    import fdtd_pkg::*;

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned INF_W = $clog2(PIPE_LATENCY+2);

    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [INF_W-1:0]           inflight, inflight_nxt;
    logic [FDTD_DATA_WIDTH-1:0] rd_data;
    logic                       empty, full, push, pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    assign pop  = bus.valid_o & bus.ready_i;
    // A pop frees the head slot this cycle, so a full buffer may still accept.
    assign push = bus.valid_i & (~full | pop);

    // DEPTH is a power of two, so the natural binary increment wraps the
    // index and toggles the wrap bit together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            inflight <= inflight_nxt;
        end
    end

    // Saturating in-flight tracker: never wraps at either end.
    always_comb begin
        inflight_nxt = inflight;
        if (bus.issue_i && !bus.valid_i) begin
            if (inflight != '1) inflight_nxt = inflight + 1'b1;
        end else if (bus.valid_i && !bus.issue_i) begin
            if (inflight != '0) inflight_nxt = inflight - 1'b1;
        end
    end

    fdtd_drain_mem #(
        .WIDTH (FDTD_DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (push),
        .waddr (wr_ptr[IDX_W-1:0]),
        .wdata (bus.data_i),
        .raddr (rd_ptr[IDX_W-1:0]),
        .rdata (rd_data)
    );

    assign bus.valid_o  = ~empty;
    assign bus.data_o   = empty ? '0 : rd_data;
    assign bus.count_o  = CNT_W'(wr_ptr - rd_ptr);
    assign bus.credit_o = (32'(bus.count_o) + 32'(inflight)) < DEPTH;

`ifdef FDTD_DRAIN_CHECK_EN
    logic err_q, err_set;

    assign err_set = (bus.issue_i & ~bus.credit_o) |
                     (bus.valid_i & full & ~pop)    |
                     (bus.valid_i & (inflight == '0));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) err_q <= 1'b0;
        else        err_q <= err_q | err_set;
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_fdtd_pipe_drain_buffer.sv
// tb_fdtd_pipe_drain_buffer: bench for fdtd_pipe_drain_buffer with a fixed-
// latency pipeline emulated in front of it and a queue-based reference model.
module tb_fdtd_pipe_drain_buffer;
    import fdtd_pkg::*;

    localparam int PL    = 2;
    localparam int DEPTH = 8;

`ifdef FDTD_DRAIN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    fdtd_pipe_drain_buffer_if #(.FDTD_DATA_WIDTH(32), .DEPTH(DEPTH)) bus ();

    fdtd_pipe_drain_buffer #(
        .FDTD_DATA_WIDTH (32),
        .PIPE_LATENCY    (PL),
        .DEPTH           (DEPTH)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: buffer contents, words in the pipeline, sticky error.
    fdtd_word_t mq[$];
    int         inflight_m;
    bit         err_m;
    bit         pv[PL];
    fdtd_word_t pd[PL];
    fdtd_word_t next_word;
    int         issued_n, popped_n;
    bit         stream_mode;

    function automatic bit credit_m();
        return (mq.size() + inflight_m) < DEPTH;
    endfunction

    task automatic check_outputs();
        chk("valid_o",  bus.valid_o, mq.size() > 0);
        chk("data_o",   bus.data_o, (mq.size() > 0) ? mq[0] : 32'h0);
        chk("count_o",  bus.count_o, mq.size());
        chk("credit_o", bus.credit_o, credit_m());
        chk("err_o",    bus.err_o, err_m);
        if (stream_mode) begin
            chk("stream_cnt_le1", bus.count_o <= 1, 1);
            chk("stream_credit",  bus.credit_o, 1);
        end
    endtask

    // One clock cycle: drive inputs, check registered outputs at the negedge,
    // advance the model and the emulated pipeline across the rising edge.
    task automatic cycle(input bit iss, input bit rdy, input bit force_v, input fdtd_word_t force_d);
        bit         v, full, pop;
        fdtd_word_t d;
        v = force_v | pv[PL-1];
        d = force_v ? force_d : pd[PL-1];
        bus.issue_i = iss;
        bus.ready_i = rdy;
        bus.valid_i = v;
        bus.data_i  = d;
        @(negedge CLK);
        check_outputs();
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && rdy;
        if (CHECK_EN && ((iss && !credit_m()) || (v && full && !pop) || (v && inflight_m == 0)))
            err_m = 1'b1;
        if (pop) begin
            void'(mq.pop_front());
            popped_n++;
        end
        if (v && (!full || pop)) mq.push_back(d);
        if (iss && !v) inflight_m++;
        else if (v && !iss && inflight_m > 0) inflight_m--;
        for (int i = PL-1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = iss;
        pd[0] = next_word;
        if (iss) begin
            next_word++;
            issued_n++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        bus.issue_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.data_i  = '0;
        #1;
        chk("rst_valid_o",  bus.valid_o, 0);
        chk("rst_data_o",   bus.data_o, 0);
        chk("rst_count_o",  bus.count_o, 0);
        chk("rst_credit_o", bus.credit_o, 1);
        chk("rst_err_o",    bus.err_o, 0);
        mq.delete();
        inflight_m = 0;
        err_m      = 1'b0;
        for (int i = 0; i < PL; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        next_word = 1;
        issued_n  = 0;
        popped_n  = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_stalled(input int n_cycles);
        for (int i = 0; i < n_cycles; i++) cycle(credit_m(), 1'b0, 1'b0, '0);
    endtask

    task automatic drain(input int n_cycles);
        for (int i = 0; i < n_cycles; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        stream_mode = 1'b0;
        #1;
        do_reset();

        // Back-to-back streaming with downstream always ready.
        stream_mode = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        drain(6);
        stream_mode = 1'b0;
        chk("stream_issued", issued_n, 20);
        chk("stream_popped", popped_n, 20);

        // Stall: only credit-granted issues, exactly DEPTH of them.
        do_reset();
        fill_stalled(20);
        chk("stall_issued", issued_n, DEPTH);
        chk("stall_count",  bus.count_o, DEPTH);
        chk("stall_credit", bus.credit_o, 0);
        drain(12);
        chk("stall_popped", popped_n, DEPTH);

        // Reset in the middle of a burst.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        do_reset();

        // Full buffer with push and pop every cycle; three trips around the pointers.
        fill_stalled(14);
        for (int i = 0; i < 3*DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b1, fdtd_word_t'(32'h100 + i));
            chk("full_pushpop_cnt", bus.count_o, DEPTH);
        end
        drain(10);
        chk("full_popped", popped_n, 4*DEPTH);

        // Protocol violations: issue without credit, then a lone valid.
        do_reset();
        fill_stalled(14);
        cycle(1'b1, 1'b0, 1'b0, '0);
        chk("err_issue_nocredit", bus.err_o, CHECK_EN);
        drain(4);
        chk("err_sticky", bus.err_o, CHECK_EN);
        drain(10);
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, fdtd_word_t'(32'hDEAD));
        chk("err_lone_valid", bus.err_o, CHECK_EN);
        drain(3);

        // Random credit-respecting traffic against the model.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(0, 3) != 0) && credit_m(), ($urandom_range(0, 3) != 0), 1'b0, '0);
        end
        drain(20);
        chk("rand_no_loss", popped_n, issued_n);
        chk("rand_empty",   bus.count_o, 0);
        chk("rand_no_err",  bus.err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
